// File: rtl/instr_issue_scheduler.sv
// In-order issue controller: buffers decoded instructions, tracks pending destination registers
// in a scoreboard and issues the queue head only when its RAW/WAW hazards are clear.
module instr_issue_scheduler #(
   parameter int DEPTH   = 4,
   parameter int ALU_LAT = 2,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic             in_regwrite,
   input  logic             in_alusrc,
   output logic             issue_valid,
   output logic [31:0]      issue_instr,
   output logic             issue_regwrite,
   output logic             issue_alusrc,
   output logic [31:0]      busy_vec,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   logic [31:0]  q_instr [DEPTH];
   logic         q_rw    [DEPTH];
   logic         q_as    [DEPTH];
   logic [PTR_W:0] wr_ptr;
   logic [PTR_W:0] rd_ptr;
   logic [4:0]   pipe    [ALU_LAT];

   logic         empty;
   logic         full;
   logic [31:0]  head_instr;
   logic         head_rw;
   logic         head_as;
   logic [4:0]   head_rd;
   logic [4:0]   head_rs1;
   logic [4:0]   head_rs2;
   logic [31:0]  clr_mask;
   logic [31:0]  set_mask;
   logic [31:0]  eff_busy;
   logic         can_issue;
   logic         do_pop;
   logic         do_push;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign in_ready = !full;

   assign head_instr = q_instr[rd_ptr[PTR_W-1:0]];
   assign head_rw    = q_rw[rd_ptr[PTR_W-1:0]];
   assign head_as    = q_as[rd_ptr[PTR_W-1:0]];
   assign head_rd    = head_instr[11:7];
   assign head_rs1   = head_instr[19:15];
   assign head_rs2   = head_instr[24:20];

   // A register leaving the latency pipe this cycle is already visible to dependents,
   // which is what lets ALU_LAT=1 issue back-to-back.
   always_comb begin
      clr_mask = '0;
      if (pipe[ALU_LAT-1] != 5'd0) clr_mask[pipe[ALU_LAT-1]] = 1'b1;
   end

   assign eff_busy  = busy_vec & ~clr_mask;
   assign can_issue = !empty && !eff_busy[head_rs1] &&
                      (head_as || !eff_busy[head_rs2]) &&
                      (!head_rw || !eff_busy[head_rd]);
   assign do_pop    = can_issue && !flush;
   assign do_push   = in_valid && !full && !flush;

   always_comb begin
      set_mask = '0;
      if (do_pop && head_rw && head_rd != 5'd0) set_mask[head_rd] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         q_instr[wr_ptr[PTR_W-1:0]] <= in_instr;
         q_rw[wr_ptr[PTR_W-1:0]]    <= in_regwrite;
         q_as[wr_ptr[PTR_W-1:0]]    <= in_alusrc;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // A re-issue of a register on the very cycle its old entry retires keeps it busy (set wins).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_vec <= '0;
         for (int i = 0; i < ALU_LAT; i++) pipe[i] <= '0;
      end else if (flush) begin
         busy_vec <= '0;
         for (int i = 0; i < ALU_LAT; i++) pipe[i] <= '0;
      end else begin
         busy_vec <= ((busy_vec & ~clr_mask) | set_mask) & ~32'h1;
         pipe[0]  <= (do_pop && head_rw) ? head_rd : 5'd0;
         for (int i = 1; i < ALU_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         issue_valid    <= 1'b0;
         issue_instr    <= '0;
         issue_regwrite <= 1'b0;
         issue_alusrc   <= 1'b0;
      end else if (do_pop) begin
         issue_valid    <= 1'b1;
         issue_instr    <= head_instr;
         issue_regwrite <= head_rw;
         issue_alusrc   <= head_as;
      end else begin
         issue_valid    <= 1'b0;
         issue_instr    <= '0;
         issue_regwrite <= 1'b0;
         issue_alusrc   <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (!flush && !empty && !can_issue && stall_cnt != '1) begin
         stall_cnt <= stall_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_instr_issue_scheduler.sv
// Bench for instr_issue_scheduler: directed vector table, hand sequences for fill/flush/reset,
// and a random phase checked against a timestamp-based reference model.
module tb_instr_issue_scheduler;

   localparam int DEPTH   = 4;
   localparam int ALU_LAT = 2;
   localparam int CNT_W   = 5;

   localparam logic [31:0] LI_X7  = 32'h00200393;
   localparam logic [31:0] LI_X8  = 32'h00500413;
   localparam logic [31:0] ADD9   = 32'h008384B3;
   localparam logic [31:0] DEC_X1 = 32'hFFF08093;
   localparam logic [31:0] NOP_X0 = 32'h00000013;
   localparam logic [31:0] ADD_X0 = 32'h00000133;

   logic             clk;
   logic             rst;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic             in_regwrite;
   logic             in_alusrc;
   logic             issue_valid;
   logic [31:0]      issue_instr;
   logic             issue_regwrite;
   logic             issue_alusrc;
   logic [31:0]      busy_vec;
   logic [CNT_W-1:0] stall_cnt;

   instr_issue_scheduler #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_regwrite(in_regwrite), .in_alusrc(in_alusrc),
      .issue_valid(issue_valid), .issue_instr(issue_instr),
      .issue_regwrite(issue_regwrite), .issue_alusrc(issue_alusrc),
      .busy_vec(busy_vec), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [31:0] instr; logic rw; logic as; } entry_t;
   typedef struct {
      logic v; logic [31:0] instr; logic rw; logic as;
      logic e_valid; logic [31:0] e_instr; logic e_rw; logic e_as;
      logic [31:0] e_busy; int e_stall; logic e_ready;
   } vec_t;

   // Reference model: a register written by an instruction issued at edge t may feed a
   // dependent issued at edge t+ALU_LAT or later.
   entry_t      mq[$];
   int          ready_at[32];
   int          edge_idx;
   int          last_edge;
   logic        m_valid;
   logic [31:0] m_instr;
   logic        m_rw;
   logic        m_as;
   int          m_stall;
   int          total;
   int          bad;

   function automatic bit avail(input logic [4:0] r, input int n);
      return (r == 5'd0) || (ready_at[r] <= n);
   endfunction

   function automatic logic [31:0] model_busy();
      logic [31:0] b;
      b = '0;
      for (int r = 1; r < 32; r++) b[r] = (ready_at[r] > last_edge);
      return b;
   endfunction

   task automatic model_reset();
      mq.delete();
      for (int r = 0; r < 32; r++) ready_at[r] = 0;
      m_valid = 0; m_instr = '0; m_rw = 0; m_as = 0; m_stall = 0;
   endtask

   task automatic model_edge(input logic v, input logic [31:0] ins, input logic rw,
                             input logic as, input logic fl, output bit acc);
      int n;
      bit room;
      entry_t h;
      entry_t e;
      n = edge_idx;
      room = (mq.size() < DEPTH);
      acc = 0;
      m_valid = 0; m_instr = '0; m_rw = 0; m_as = 0;
      if (fl) begin
         mq.delete();
         for (int r = 0; r < 32; r++) ready_at[r] = 0;
      end else begin
         if (mq.size() > 0) begin
            h = mq[0];
            if (avail(h.instr[19:15], n) && (h.as || avail(h.instr[24:20], n)) &&
                (!h.rw || avail(h.instr[11:7], n))) begin
               void'(mq.pop_front());
               m_valid = 1; m_instr = h.instr; m_rw = h.rw; m_as = h.as;
               if (h.rw && h.instr[11:7] != 5'd0) ready_at[h.instr[11:7]] = n + ALU_LAT;
            end else if (m_stall < (1 << CNT_W) - 1) begin
               m_stall++;
            end
         end
         if (v && room) begin
            e.instr = ins; e.rw = rw; e.as = as;
            mq.push_back(e);
            acc = 1;
         end
      end
      last_edge = n;
      edge_idx++;
   endtask

   task automatic cmp(input string name, input string field, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s.%s actual=%h required=%h", name, field, act, exp);
      end
   endtask

   task automatic checkOutput(input string name, input logic e_valid, input logic [31:0] e_instr,
                              input logic e_rw, input logic e_as, input logic [31:0] e_busy,
                              input int e_stall, input logic e_ready);
      cmp(name, "issue_valid", {31'b0, issue_valid}, {31'b0, e_valid});
      cmp(name, "issue_instr", issue_instr, e_instr);
      cmp(name, "issue_regwrite", {31'b0, issue_regwrite}, {31'b0, e_rw});
      cmp(name, "issue_alusrc", {31'b0, issue_alusrc}, {31'b0, e_as});
      cmp(name, "busy_vec", busy_vec, e_busy);
      cmp(name, "stall_cnt", 32'(stall_cnt), e_stall);
      cmp(name, "in_ready", {31'b0, in_ready}, {31'b0, e_ready});
   endtask

   task automatic checkModel(input string name);
      checkOutput(name, m_valid, m_instr, m_rw, m_as, model_busy(), m_stall, mq.size() < DEPTH);
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic rw,
                                input logic as, input logic fl, output bit acc);
      in_valid = v; in_instr = ins; in_regwrite = rw; in_alusrc = as; flush = fl;
      model_edge(v, ins, rw, as, fl, acc);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t        tbl[7];
      bit          acc;
      bit          dut_full_seen;
      bit          mdl_full_seen;
      int          idx;
      int          budget;
      logic [31:0] fill_list[10];
      logic [31:0] r;

      total = 0; bad = 0; edge_idx = 0; last_edge = 0;
      rst = 1'b0; flush = 0; in_valid = 0; in_instr = '0; in_regwrite = 0; in_alusrc = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, '0, 0, 0, 0, acc);
         checkOutput("idle", 0, '0, 0, 0, '0, 0, 1);
      end

      tbl[0] = '{1, LI_X7, 1, 1, 0, 32'h0,  0, 0, 32'h000, 0, 1};
      tbl[1] = '{1, LI_X8, 1, 1, 1, LI_X7,  1, 1, 32'h080, 0, 1};
      tbl[2] = '{1, ADD9,  1, 0, 1, LI_X8,  1, 1, 32'h180, 0, 1};
      tbl[3] = '{0, 32'h0, 0, 0, 0, 32'h0,  0, 0, 32'h100, 1, 1};
      tbl[4] = '{0, 32'h0, 0, 0, 1, ADD9,   1, 0, 32'h200, 1, 1};
      tbl[5] = '{0, 32'h0, 0, 0, 0, 32'h0,  0, 0, 32'h200, 1, 1};
      tbl[6] = '{0, 32'h0, 0, 0, 0, 32'h0,  0, 0, 32'h000, 1, 1};
      for (int i = 0; i < 7; i++) begin
         applyStimulus(tbl[i].v, tbl[i].instr, tbl[i].rw, tbl[i].as, 0, acc);
         checkOutput($sformatf("lat2_row%0d", i), tbl[i].e_valid, tbl[i].e_instr, tbl[i].e_rw,
                     tbl[i].e_as, tbl[i].e_busy, tbl[i].e_stall, tbl[i].e_ready);
      end

      // A dependent chain stalls every other cycle, so a steady offer fills the queue.
      for (int i = 0; i < 8; i++) fill_list[i] = DEC_X1;
      fill_list[8] = 32'h00A00513;
      fill_list[9] = 32'h00B00593;
      idx = 0; budget = 0; dut_full_seen = 0; mdl_full_seen = 0;
      while (idx < 10 && budget < 200) begin
         applyStimulus(1, fill_list[idx], 1, 1, 0, acc);
         checkModel("fill");
         if (acc) idx++;
         if (!in_ready) dut_full_seen = 1;
         if (mq.size() == DEPTH) mdl_full_seen = 1;
         budget++;
      end
      cmp("fill", "all_accepted", idx, 10);
      cmp("fill", "reached_full", {31'b0, dut_full_seen}, {31'b0, mdl_full_seen});
      for (int i = 0; i < 20; i++) begin
         applyStimulus(0, '0, 0, 0, 0, acc);
         checkModel("drain");
      end

      applyStimulus(1, DEC_X1, 1, 1, 0, acc); checkModel("waw");
      applyStimulus(1, DEC_X1, 1, 1, 0, acc); checkModel("waw");
      applyStimulus(1, NOP_X0, 1, 1, 0, acc); checkModel("x0");
      applyStimulus(1, ADD_X0, 1, 0, 0, acc); checkModel("x0");
      for (int i = 0; i < 6; i++) begin
         applyStimulus(0, '0, 0, 0, 0, acc);
         checkModel("waw_x0_tail");
      end

      for (int i = 0; i < 6; i++) begin
         applyStimulus(1, DEC_X1, 1, 1, 0, acc);
         checkModel("pre_flush");
      end
      cmp("pre_flush", "model_depth", mq.size(), 3);
      applyStimulus(1, LI_X7, 1, 1, 1, acc);
      checkModel("flush");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, '0, 0, 0, 0, acc);
         checkModel("post_flush");
      end

      applyStimulus(1, LI_X7, 1, 1, 0, acc); checkModel("pre_rst");
      applyStimulus(1, DEC_X1, 1, 1, 0, acc); checkModel("pre_rst");
      applyStimulus(1, ADD9, 1, 0, 0, acc); checkModel("pre_rst");
      #3 rst = 1'b0;
      #1;
      model_reset();
      checkOutput("async_rst", 0, '0, 0, 0, '0, 0, 1);
      @(posedge clk);
      #3 rst = 1'b1;
      in_valid = 0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(i < 2, (i == 0) ? LI_X8 : ADD9, 1, i != 1, 0, acc);
         checkModel("resume");
      end
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, '0, 0, 0, 0, acc);
         checkModel("resume_tail");
      end

      for (int i = 0; i < 600; i++) begin
         r = $urandom;
         r[11:7]  = 5'($urandom_range(0, 5));
         r[19:15] = 5'($urandom_range(0, 5));
         r[24:20] = 5'($urandom_range(0, 5));
         applyStimulus($urandom_range(0, 3) != 0, r, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0, acc);
         checkModel("random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
